iterative_shifter: RTL
======================

Name: iterative_shifter

Overview:
- Multi-cycle parametrised shifter for the datapath; replaces fixed combinational shift-by-constant blocks.
- Takes an operand, shift amount and mode on a start pulse, then shifts up to STEP bits per clock.
- Presents a held result with a one-cycle done pulse.
- Supports logical left, logical right, arithmetic right and rotate left, at any width.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SHAMT_W, 4, width of the shift-amount input.
- STEP, 1, maximum bits shifted per clock. Must be a power of two and at most WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL; latched at start.
- shamt  input  SHAMT_W  shift amount; latched at start.
- in  input  WIDTH  operand; latched at start.
- out  output  WIDTH  registered result; held until the next result is produced.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse, high in the cycle in which out first shows a new result.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset:
  - state=IDLE, out=0, busy=0, done=0, internal accumulator and counter cleared.
  - Reset overrides start in the same cycle.
  - Reset mid-operation aborts the shift; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, start=1 at edge k:
  - Latch in, mode and shamt. acc=in, cnt=shamt.
  - If shamt==0: go to DONE at edge k, out=in, done=1 in the following cycle.
  - Otherwise: go to SHIFT, busy=1.
- SHIFT, each edge:
  - s = min(STEP, cnt); acc shifted by s per the latched mode; cnt = cnt - s.
  - When cnt reaches 0 at this edge: out=new acc, state=DONE, busy=0, done=1.
- Latency: done is high in the cycle after edge k+L, where L = ceil(shamt/STEP). busy is high for exactly L cycles.
- DONE:
  - done is high for one cycle only.
  - Without start, go to IDLE at the next edge; out holds its value.
  - start in DONE is accepted exactly as in IDLE, giving back-to-back operations with no bubble.
- start while in SHIFT is ignored. Inputs may change freely during SHIFT.
- Mode arithmetic per shift of s bits:
  - SLL: zero fill on the LSBs.
  - SRL: zero fill on the MSBs.
  - SRA: MSB replicated from the latched operand's sign bit.
  - ROL: bits leaving the MSB re-enter at the LSB.
- shamt >= WIDTH (possible when 2^SHAMT_W > WIDTH): iteration continues without special casing.
  - SLL/SRL give 0.
  - SRA gives all copies of the sign bit.
  - ROL gives rotation by shamt mod WIDTH.
- out never changes except at entry to DONE or at reset; intermediate acc values are never visible.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=16, STEP=1, SLL, in=16'h3FFF, shamt=2, pulse start -> busy high 2 cycles, done pulse, out=16'hFFFC.
- SLL, in=16'h0001, shamt=2 -> out=16'h0004; out still 16'h0004 five cycles after done with start low.
- SRL, in=16'h8010, shamt=4 -> out=16'h0801. Repeat with SRA -> out=16'hF801.
- ROL, in=16'h8001, shamt=1 -> out=16'h0003. Then shamt=0, in=16'hABCD -> busy never high, done in cycle after start, out=16'hABCD.
- SLL, in=16'h00FF, shamt=8, start; at cycle 3 re-pulse start with in=16'h1234 -> second start ignored, out=16'hFF00. Second run, reset asserted at cycle 3 -> out=0, busy=0, no done.
- WIDTH=16, STEP=4, SLL, in=16'h0001, shamt=13 -> busy 4 cycles (4,4,4,1), out=16'h2000. Back-to-back start in DONE cycle with SRA, in=16'h8000, shamt=15 -> out=16'hFFFF.

Source files
------------

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: latches operand, amount and mode on start, then shifts up
// to STEP bits per clock and presents a held result with a one-cycle done pulse.
module iterative_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  state_t             state_r;
  logic [WIDTH-1:0]   acc_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [1:0]         mode_r;
  logic               sign_r;
  logic [WIDTH-1:0]   out_r;
  logic               busy_r;
  logic               done_r;

  logic [31:0]        step_amt_s;
  logic [SHAMT_W-1:0] cnt_next_s;
  logic [WIDTH-1:0]   acc_next_s;

  // One partial shift of s bits (0..STEP); s may equal WIDTH when STEP == WIDTH,
  // so the SRA/ROL cases go through a double-width vector to stay well defined.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] a,
    input logic [1:0]       m,
    input logic             sgn,
    input logic [31:0]      s
  );
    logic [2*WIDTH-1:0] wide;
    wide = '0;
    case (m)
      MODE_SLL: shift_step = a << s;
      MODE_SRL: shift_step = a >> s;
      MODE_SRA: begin
        wide       = {{WIDTH{sgn}}, a} >> s;
        shift_step = wide[WIDTH-1:0];
      end
      MODE_ROL: begin
        wide       = {a, a} << s;
        shift_step = wide[2*WIDTH-1:WIDTH];
      end
      default: shift_step = a;
    endcase
  endfunction

  // Per-clock step size min(STEP, cnt) and the next accumulator/counter values
  always_comb begin
    step_amt_s = 32'd0;
    if (32'(cnt_r) > 32'(STEP)) begin
      step_amt_s = 32'(STEP);
    end else begin
      step_amt_s = 32'(cnt_r);
    end
    cnt_next_s = cnt_r - SHAMT_W'(step_amt_s);
    acc_next_s = shift_step(acc_r, mode_r, sign_r, step_amt_s);
  end

  // Control FSM with registered result, busy and done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= '0;
      cnt_r   <= '0;
      mode_r  <= 2'b00;
      sign_r  <= 1'b0;
      out_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_r  <= in;
            cnt_r  <= shamt;
            mode_r <= mode;
            sign_r <= in[WIDTH-1];
            if (shamt == '0) begin
              state_r <= DONE;
              out_r   <= in;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_next_s;
          // start is deliberately not looked at here: a running shift cannot be restarted
          if (cnt_next_s == '0) begin
            state_r <= DONE;
            out_r   <= acc_next_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
